// File: rtl/rgb_to_ycbcr_cfg.sv
// RGB to YCbCr converter: run-time BT.601/BT.709 full-range coefficients,
// 4:4:4 or 4:2:2 packing, fixed 4-cycle latency, sticky protocol/saturation flags.
module rgb_to_ycbcr_cfg #(
  parameter int MD_SIM_ABLE = 0,
  parameter int WD_IMG_DATA = 8,
  parameter int WD_ERR_INFO = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   i_cfg_std,
  input  logic                   i_cfg_422,
  input  logic                   s_img_rgb_c_fsync,
  input  logic                   s_img_rgb_c_vsync,
  input  logic                   s_img_rgb_c_hsync,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_r_mdat0,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_g_mdat1,
  input  logic [WD_IMG_DATA-1:0] s_img_rgb_b_mdat2,
  output logic                   m_img_ycbcr_c_fsync,
  output logic                   m_img_ycbcr_c_vsync,
  output logic                   m_img_ycbcr_c_hsync,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_y_mdat0,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_c_mdat1,
  output logic [WD_IMG_DATA-1:0] m_img_ycbcr_r_mdat2,
  output logic [WD_ERR_INFO-1:0] m_err_rgb_info1
);
  localparam int WD = WD_IMG_DATA;
  localparam int AW = WD + 10;
  localparam logic signed [AW-1:0] ROUND = AW'(128);
  localparam logic signed [AW-1:0] C_OFF = AW'(2 ** (WD + 7));
  localparam logic signed [AW-1:0] MAXV  = AW'(2 ** WD - 1);

  // Row-major {Y,Cb,Cr} x {R,G,B}; std selects BT.709 when set.
  function automatic logic signed [9:0] coef(input logic std, input int idx);
    logic signed [9:0] c;
    case (idx)
      0:       c = std ? 10'sd54 : 10'sd77;
      1:       c = std ? 10'sd183 : 10'sd150;
      2:       c = std ? 10'sd19 : 10'sd29;
      3:       c = std ? -10'sd29 : -10'sd43;
      4:       c = std ? -10'sd99 : -10'sd85;
      5:       c = 10'sd128;
      6:       c = 10'sd128;
      7:       c = std ? -10'sd116 : -10'sd107;
      default: c = std ? -10'sd12 : -10'sd21;
    endcase
    return c;
  endfunction

  logic [2:0][WD-1:0] px1_reg;
  logic [2:0]         sync1_reg, sync2_reg, sync3_reg;
  logic               std_sh_reg, c422_sh_reg, c422_2_reg, c422_3_reg;
  logic               parity_reg;
  logic [3:0]         err_reg, err_next;
  logic [15:0]        line_cnt_reg, line_cnt_next, first_len_reg, first_len_next;
  logic               first_done_reg, first_done_next;
  logic               fsync_rise, vsync_fall, pix_in, len_err, clamp_any, sel_cr;

  assign fsync_rise = s_img_rgb_c_fsync & ~sync1_reg[2];
  assign vsync_fall = sync1_reg[1] & ~s_img_rgb_c_vsync;
  assign pix_in     = s_img_rgb_c_hsync & s_img_rgb_c_vsync;

  // S1: input capture; config shadows only move on the frame-start edge.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      px1_reg     <= '0;
      sync1_reg   <= '0;
      std_sh_reg  <= 1'b0;
      c422_sh_reg <= 1'b0;
    end else begin
      px1_reg     <= {s_img_rgb_b_mdat2, s_img_rgb_g_mdat1, s_img_rgb_r_mdat0};
      sync1_reg   <= {s_img_rgb_c_fsync, s_img_rgb_c_vsync, s_img_rgb_c_hsync};
      std_sh_reg  <= fsync_rise ? i_cfg_std : std_sh_reg;
      c422_sh_reg <= fsync_rise ? i_cfg_422 : c422_sh_reg;
    end
  end

  genvar gi;
  // S2: nine signed products.
  for (gi = 0; gi < 9; gi++) begin : g_prod
    logic signed [9:0]    c;
    logic signed [AW-1:0] px_ext, co_ext, prod_reg;
    assign c      = coef(std_sh_reg, gi);
    assign co_ext = {{(AW-10){c[9]}}, c};
    assign px_ext = $signed({{(AW-WD){1'b0}}, px1_reg[gi % 3]});
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) prod_reg <= '0;
      else               prod_reg <= px_ext * co_ext;
    end
  end

  // S3: sum plus offset and rounding; S4 comb: shift and clamp.
  for (gi = 0; gi < 3; gi++) begin : g_sum
    localparam logic signed [AW-1:0] BIAS = (gi == 0) ? ROUND : ROUND + C_OFF;
    logic signed [AW-1:0] sum_reg, shifted;
    logic [WD-1:0]        clip;
    logic                 clamp;
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) sum_reg <= '0;
      else sum_reg <= g_prod[3*gi].prod_reg + g_prod[3*gi+1].prod_reg
                      + g_prod[3*gi+2].prod_reg + BIAS;
    end
    always_comb begin
      shifted = sum_reg >>> 8;
      clip    = shifted[WD-1:0];
      clamp   = 1'b0;
      if (shifted < 0) begin
        clip  = '0;
        clamp = 1'b1;
      end else if (shifted > MAXV) begin
        clip  = '1;
        clamp = 1'b1;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      sync2_reg  <= '0;
      sync3_reg  <= '0;
      c422_2_reg <= 1'b0;
      c422_3_reg <= 1'b0;
    end else begin
      sync2_reg  <= sync1_reg;
      sync3_reg  <= sync2_reg;
      c422_2_reg <= c422_sh_reg;
      c422_3_reg <= c422_2_reg;
    end
  end

  // Odd pixels of a 4:2:2 line carry Cr on the shared chroma lane.
  assign sel_cr    = c422_3_reg & sync3_reg[1] & parity_reg;
  assign clamp_any = (g_sum[0].clamp | g_sum[1].clamp | g_sum[2].clamp) & sync3_reg[0];

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      m_img_ycbcr_c_fsync <= 1'b0;
      m_img_ycbcr_c_vsync <= 1'b0;
      m_img_ycbcr_c_hsync <= 1'b0;
      m_img_ycbcr_y_mdat0 <= '0;
      m_img_ycbcr_c_mdat1 <= '0;
      m_img_ycbcr_r_mdat2 <= '0;
      parity_reg          <= 1'b0;
    end else begin
      {m_img_ycbcr_c_fsync, m_img_ycbcr_c_vsync, m_img_ycbcr_c_hsync} <= sync3_reg;
      m_img_ycbcr_y_mdat0 <= g_sum[0].clip;
      m_img_ycbcr_c_mdat1 <= sel_cr ? g_sum[2].clip : g_sum[1].clip;
      m_img_ycbcr_r_mdat2 <= c422_3_reg ? '0 : g_sum[2].clip;
      parity_reg          <= sync3_reg[1] ? (parity_reg ^ sync3_reg[0]) : 1'b0;
    end
  end

  // Line-length tracking against the first complete line of the frame.
  always_comb begin
    line_cnt_next   = line_cnt_reg;
    first_len_next  = first_len_reg;
    first_done_next = first_done_reg;
    len_err         = 1'b0;
    if (fsync_rise) begin
      first_done_next = 1'b0;
      line_cnt_next   = {15'd0, pix_in};
    end else if (vsync_fall) begin
      if (!first_done_reg) begin
        first_done_next = 1'b1;
        first_len_next  = line_cnt_reg;
      end else if (line_cnt_reg != first_len_reg) begin
        len_err = 1'b1;
      end
      line_cnt_next = '0;
    end else if (pix_in) begin
      line_cnt_next = line_cnt_reg + 16'd1;
    end
    err_next = (fsync_rise ? 4'd0 : err_reg)
             | {clamp_any, len_err,
                s_img_rgb_c_vsync & ~s_img_rgb_c_fsync,
                s_img_rgb_c_hsync & ~s_img_rgb_c_vsync};
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      err_reg        <= '0;
      line_cnt_reg   <= '0;
      first_len_reg  <= '0;
      first_done_reg <= 1'b0;
    end else begin
      err_reg        <= err_next;
      line_cnt_reg   <= line_cnt_next;
      first_len_reg  <= first_len_next;
      first_done_reg <= first_done_next;
    end
  end

  always_comb begin
    m_err_rgb_info1      = '0;
    m_err_rgb_info1[3:0] = err_reg;
  end

  if (MD_SIM_ABLE != 0) begin : g_sim_chk
    always_ff @(posedge i_sys_clk) begin
      if (i_sys_resetn) assert (m_img_ycbcr_c_vsync || !parity_reg);
    end
  end
endmodule

// File: tb/tb_rgb_to_ycbcr_cfg.sv
// Bench for rgb_to_ycbcr_cfg: directed and random frames checked against a
// behavioural model of the conversion, packing and sticky error rules.
module tb_rgb_to_ycbcr_cfg;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cfg_std = 1'b0, cfg_422 = 1'b0;
  logic       fs = 1'b0, vs = 1'b0, hs = 1'b0;
  logic [7:0] r = 8'd0, g = 8'd0, b = 8'd0;
  logic       m_f, m_v, m_h;
  logic [7:0] m_y, m_c1, m_c2;
  logic [3:0] m_err;

  always #5 clk = ~clk;

  rgb_to_ycbcr_cfg dut (
    .i_sys_clk(clk), .i_sys_resetn(rst_n), .i_cfg_std(cfg_std), .i_cfg_422(cfg_422),
    .s_img_rgb_c_fsync(fs), .s_img_rgb_c_vsync(vs), .s_img_rgb_c_hsync(hs),
    .s_img_rgb_r_mdat0(r), .s_img_rgb_g_mdat1(g), .s_img_rgb_b_mdat2(b),
    .m_img_ycbcr_c_fsync(m_f), .m_img_ycbcr_c_vsync(m_v), .m_img_ycbcr_c_hsync(m_h),
    .m_img_ycbcr_y_mdat0(m_y), .m_img_ycbcr_c_mdat1(m_c1), .m_img_ycbcr_r_mdat2(m_c2),
    .m_err_rgb_info1(m_err)
  );

  typedef struct {
    logic f, v, h;
    int   y, cb, cr;
    bit   clamp;
    bit   c422;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, fails = 0;
  int         cf[2][9] = '{'{77, 150, 29, -43, -85, 128, 128, -107, -21},
                           '{54, 183, 19, -29, -99, 128, 128, -116, -12}};
  bit         sh_std, sh_422, pf, pv, odd;
  int         first_len, cnt;
  logic [3:0] err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Full-range conversion: floor((sum + offset + 128) / 256), clamped to 8 bits.
  function automatic int conv(input int kr, kg, kb, input int rr, gg, bb, input int off,
                              output bit cl);
    int s, v;
    s  = kr * rr + kg * gg + kb * bb + off + 128;
    v  = (s + 1048576) / 256 - 4096;
    cl = (v < 0) || (v > 255);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{f: 0, v: 0, h: 0, y: 0, cb: 0, cr: 0, clamp: 0, c422: 0};
    q.delete();
    repeat (3) q.push_back(z);
    sh_std = 0; sh_422 = 0; pf = 0; pv = 0; odd = 0;
    first_len = -1; cnt = 0; err_m = 4'd0;
  endtask

  // One clock: account for the edge just taken, compare outputs, drive the next input.
  task automatic step(input logic f, v, h, input logic [7:0] rr, gg, bb);
    exp_t n, e;
    bit   rise, vfall, lerr, sel, c0, c1, c2;
    int   k;
    @(negedge clk);
    rise  = fs && !pf;
    vfall = pv && !vs;
    if (rise) begin sh_std = cfg_std; sh_422 = cfg_422; end
    k      = sh_std ? 1 : 0;
    n.f    = fs; n.v = vs; n.h = hs; n.c422 = sh_422;
    n.y    = conv(cf[k][0], cf[k][1], cf[k][2], r, g, b, 0, c0);
    n.cb   = conv(cf[k][3], cf[k][4], cf[k][5], r, g, b, 32768, c1);
    n.cr   = conv(cf[k][6], cf[k][7], cf[k][8], r, g, b, 32768, c2);
    n.clamp = c0 | c1 | c2;
    q.push_back(n);
    e = q.pop_front();
    sel = e.c422 && e.v && odd;
    if (!e.v) odd = 0;
    else if (e.h) odd = !odd;
    lerr = 0;
    if (rise) begin
      first_len = -1;
      cnt = (hs && vs) ? 1 : 0;
    end else if (vfall) begin
      if (first_len < 0) first_len = cnt;
      else if (cnt != first_len) lerr = 1;
      cnt = 0;
    end else if (hs && vs) begin
      cnt++;
    end
    if (rise) err_m = 4'd0;
    err_m |= {e.clamp && e.h, lerr, vs && !fs, hs && !vs};
    pf = fs; pv = vs;
    chk("sync", {29'd0, m_f, m_v, m_h}, {29'd0, e.f, e.v, e.h});
    if (e.h) begin
      chk("y", m_y, e.y);
      chk("mdat1", m_c1, sel ? e.cr : e.cb);
      chk("mdat2", m_c2, e.c422 ? 0 : e.cr);
    end
    chk("info1", m_err, err_m);
    fs = f; vs = v; hs = h; r = rr; g = gg; b = bb;
  endtask

  task automatic frame(input int nl, input int len, input bit rnd,
                       input logic [7:0] r0, g0, b0, input bit tog, input bit bad);
    logic [7:0] pr, pg, pb;
    int n;
    step(1, 0, 0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      n = len + ((bad && l == nl - 1) ? 1 : 0);
      for (int p = 0; p < n; p++) begin
        pr = r0; pg = g0; pb = b0;
        if (rnd) begin
          pr = 8'($urandom_range(0, 255));
          pg = 8'($urandom_range(0, 255));
          pb = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) step(1, 1, 0, pb, pr, pg);
        end
        step(1, 1, 1, pr, pg, pb);
      end
      step(1, 0, bad && l == 0, 8'd9, 8'd9, 8'd9);
      if (tog && l == 0) cfg_std = !cfg_std;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sync", {29'd0, m_f, m_v, m_h}, 32'd0);
    chk("rst_y", m_y, 32'd0);
    chk("rst_mdat1", m_c1, 32'd0);
    chk("rst_mdat2", m_c2, 32'd0);
    chk("rst_info1", m_err, 32'd0);
    rst_n = 1'b1;

    cfg_std = 0; cfg_422 = 0;
    frame(2, 4, 0, 8'd255, 8'd255, 8'd255, 0, 0);
    frame(2, 4, 0, 8'd255, 8'd0, 8'd0, 0, 0);
    cfg_std = 1;
    frame(2, 3, 0, 8'd255, 8'd0, 8'd0, 0, 0);
    frame(2, 3, 0, 8'd0, 8'd0, 8'd0, 0, 0);
    cfg_std = 0; cfg_422 = 1;
    frame(2, 4, 0, 8'd255, 8'd0, 8'd0, 0, 0);
    cfg_422 = 0;
    frame(3, 4, 0, 8'd255, 8'd0, 8'd0, 1, 0);
    cfg_std = 0;
    frame(3, 5, 1, 8'd0, 8'd0, 8'd0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    frame(2, 4, 0, 8'd10, 8'd200, 8'd30, 0, 0);

    for (int i = 0; i < 6; i++) begin
      cfg_std = 1'($urandom_range(0, 1));
      cfg_422 = 1'($urandom_range(0, 1));
      frame(int'($urandom_range(2, 4)), int'($urandom_range(1, 9)), 1, 0, 0, 0, 0,
            1'($urandom_range(0, 1)));
    end

    // Reset mid-line with clamped pixels in flight.
    cfg_std = 0; cfg_422 = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int p = 0; p < 6; p++) step(1, 1, 1, 8'd255, 8'd0, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_sync", {29'd0, m_f, m_v, m_h}, 32'd0);
    chk("rstmid_y", m_y, 32'd0);
    chk("rstmid_mdat1", m_c1, 32'd0);
    chk("rstmid_mdat2", m_c2, 32'd0);
    chk("rstmid_info1", m_err, 32'd0);
    fs = 0; vs = 0; hs = 0; r = 0; g = 0; b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cfg_422 = 1;
    frame(2, 5, 1, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
